// File: rtl/lcd_text_writer.sv
// Push-button character entry: debounced presses queue ASCII codes in a FIFO,
// and an HD44780-style write FSM prints them with automatic line wrapping.
module lcd_text_writer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 16,
  parameter int SETUP_CYCLES    = 3,
  parameter int E_PULSE_CYCLES  = 12,
  parameter int EXEC_CYCLES     = 2500,
  parameter int COLS            = 16,
  parameter int ROWS            = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_btn,
  input  logic       button,
  input  logic       debounce_en,
  output logic       RW_btn_lcd,
  output logic       RS_btn_lcd,
  output logic       E_btn_lcd,
  output logic [7:0] data_btn_lcd,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(COLS + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_WAIT} state_t;

  logic        sync1_q, sync2_q;
  logic        level_q, level_d, en_q;
  logic [31:0] db_cnt_q, db_cnt_d;
  logic        press_d;
  logic        push_q;
  logic [7:0]  pdata_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            full, empty, pop, wr_en, overflow_q;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        rs_q, rs_d, cmd_q, cmd_d;
  logic [7:0]  data_q, data_d;
  logic [CW-1:0] col_q, col_d;
  logic        row_q, row_d, row_nx;

  // Accepted level; a change of debounce_en in this cycle masks the edge so
  // switching the filter off cannot fabricate a press.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (!debounce_en) begin
      level_d = sync2_q;
    end else if (sync2_q != level_q) begin
      if (db_cnt_q == 32'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else db_cnt_d = db_cnt_q + 32'd1;
    end
    press_d = level_d & ~level_q & (debounce_en == en_q);
  end

  always_ff @(posedge clk) en_q <= debounce_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      push_q   <= 1'b0;
      pdata_q  <= '0;
    end else begin
      sync1_q  <= button;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      push_q   <= press_d;
      pdata_q  <= data_btn;
    end
  end

  assign full  = (count_q == CNTW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = push_q & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !pop)      count_q <= count_q + CNTW'(1);
      else if (!wr_en && pop) count_q <= count_q - CNTW'(1);
      if (push_q && !wr_en) overflow_q <= 1'b1;
    end
  end

  assign row_nx = (ROWS > 1) ? ~row_q : 1'b0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    col_d   = col_q;
    row_d   = row_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          rs_d    = 1'b1;
          cmd_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 32'(SETUP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_PULSE;
        end else cnt_d = cnt_q + 32'd1;
      end
      S_PULSE: begin
        if (cnt_q == 32'(E_PULSE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else cnt_d = cnt_q + 32'd1;
      end
      S_WAIT: begin
        if (cnt_q == 32'(EXEC_CYCLES - 1)) begin
          cnt_d = '0;
          if (cmd_q) begin
            cmd_d   = 1'b0;
            state_d = S_IDLE;
          end else if (col_q == CW'(COLS - 1)) begin
            // Line full: chain the DDRAM address command without visiting IDLE.
            col_d   = '0;
            row_d   = row_nx;
            rs_d    = 1'b0;
            data_d  = row_nx ? 8'hC0 : 8'h80;
            cmd_d   = 1'b1;
            state_d = S_SETUP;
          end else begin
            col_d   = col_q + CW'(1);
            state_d = S_IDLE;
          end
        end else cnt_d = cnt_q + 32'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      cmd_q   <= 1'b0;
      col_q   <= '0;
      row_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  assign RW_btn_lcd   = 1'b0;
  assign RS_btn_lcd   = rs_q;
  assign data_btn_lcd = data_q;
  assign E_btn_lcd    = (state_q == S_PULSE);
  assign busy         = (state_q != S_IDLE);
  assign fifo_full    = full;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Bench for lcd_text_writer: captures every LCD write on E rising and compares
// against a cursor/line-wrap model fed with the characters that were pressed.
module tb_lcd_text_writer;

  localparam int DB = 4, DEPTH = 4, SETUP = 2, PULSE = 3, EXEC = 5, COLS = 4, ROWS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_btn = '0;
  logic       button = 1'b0;
  logic       debounce_en = 1'b1;
  logic       RW, RS, E, busy, full, ovf;
  logic [7:0] dout;

  lcd_text_writer #(
    .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SETUP),
    .E_PULSE_CYCLES(PULSE), .EXEC_CYCLES(EXEC), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .clk(clk), .reset(reset), .data_btn(data_btn), .button(button),
    .debounce_en(debounce_en), .RW_btn_lcd(RW), .RS_btn_lcd(RS),
    .E_btn_lcd(E), .data_btn_lcd(dout), .busy(busy), .fifo_full(full),
    .overflow(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];
  int m_col, m_row;
  logic e_prev = 1'b0;
  logic full_seen = 1'b0;

  always @(negedge clk) begin
    if (E && !e_prev) obs_q.push_back({RS, dout});
    e_prev = E;
    if (full) full_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: each character lands at the cursor; filling a line emits the
  // DDRAM address of the next (wrapping) line.
  task automatic model_char(input logic [7:0] ch);
    exp_q.push_back({1'b1, ch});
    m_col++;
    if (m_col == COLS) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
      exp_q.push_back({1'b0, (m_row == 1) ? 8'hC0 : 8'h80});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    m_col = 0;
    m_row = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic press_slow(input logic [7:0] ch);
    data_btn = ch;
    button = 1'b1;
    tick(10);
    button = 1'b0;
    tick(10);
  endtask

  // One-cycle pulse; data moves on the low phase so it stays valid across the
  // 2-3 cycle synchronizer latency of its own press.
  task automatic press_fast(input logic [7:0] ch);
    button = 1'b1;
    tick(1);
    button = 1'b0;
    data_btn = ch;
    tick(1);
  endtask

  task automatic wait_idle(output bit ok);
    int quiet = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
      if (quiet >= 20) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    n_checks++;
    if ({E, RS, RW, dout, busy, full, ovf} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got E=%b RS=%b RW=%b data=%h busy=%b full=%b ovf=%b, want all 0",
               E, RS, RW, dout, busy, full, ovf);
    end
    reset = 1'b0;
    tick(5);
    n_checks++;
    if (busy !== 1'b0 || E !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b E=%b, want 0 0", busy, E);
    end
    m_col = 0;
    m_row = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_single();
    bit ok;
    bit seen;
    do_reset();
    debounce_en = 1'b1;
    fork
      begin
        press_slow(8'h41);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
          @(negedge clk);
          seen = busy;
        end
        n_checks++;
        if (!seen) begin
          n_fail++;
          $display("FAIL single_start: busy never rose within 100 cycles, want 1");
        end else begin
          for (int c = 0; c < SETUP + PULSE + EXEC; c++) begin
            n_checks++;
            if (E !== ((c >= SETUP) && (c < SETUP + PULSE))) begin
              n_fail++;
              $display("FAIL single_e_cycle%0d: got E=%b, want %b", c, E, (c >= SETUP) && (c < SETUP + PULSE));
            end
            n_checks++;
            if ({RS, dout} !== 9'h141) begin
              n_fail++;
              $display("FAIL single_bus_cycle%0d: got RS=%b data=%h, want RS=1 data=41", c, RS, dout);
            end
            @(negedge clk);
          end
          n_checks++;
          if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got busy=%b, want 0", busy);
          end
        end
      end
    join
    model_char(8'h41);
    wait_idle(ok);
    n_checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_stream: got %0d writes (idle=%0d), want %0d", obs_q.size(), ok, exp_q.size());
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_bounce();
    bit ok;
    logic [7:0] ch;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      debounce_en = (pass == 0);
      tick(4);
      ch = 8'($urandom_range(8'h20, 8'h7e));
      data_btn = ch;
      button = 1'b1; tick(2);
      button = 1'b0; tick(2);
      button = 1'b1; tick(10);
      button = 1'b0; tick(10);
      model_char(ch);
      if (pass == 1) model_char(ch);
      wait_idle(ok);
      n_checks++;
      if (!ok || obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL bounce_count_en%0d: got %0d writes (idle=%0d), want %0d",
                 debounce_en, obs_q.size(), ok, exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL bounce_write%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
        end
      end
      obs_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] ch;
    do_reset();
    debounce_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ch = 8'h31 + 8'(i);
      press_slow(ch);
      model_char(ch);
    end
    for (int i = 0; i < 3; i++) begin
      ch = 8'($urandom_range(8'h20, 8'h7e));
      press_slow(ch);
      model_char(ch);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL wrap_count: got %0d writes (idle=%0d), want %0d", obs_q.size(), ok, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_write%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] ch;
    int n;
    debounce_en = 1'b1;
    n = $urandom_range(5, 8);
    for (int i = 0; i < n; i++) begin
      ch = 8'($urandom);
      press_slow(ch);
      model_char(ch);
      tick($urandom_range(0, 15));
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || obs_q.size() != exp_q.size() || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL random_count: got %0d writes ovf=%b (idle=%0d), want %0d ovf=0",
               obs_q.size(), ovf, ok, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_write%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] base;
    do_reset();
    debounce_en = 1'b0;
    tick(4);
    full_seen = 1'b0;
    base = 8'($urandom_range(0, 200));
    // First press goes straight to the writer; the next four fill the FIFO
    // and the sixth arrives while it is still full.
    for (int j = 0; j < 6; j++) begin
      press_fast(base + 8'(j));
      if (j < 5) model_char(base + 8'(j));
    end
    wait_idle(ok);
    n_checks++;
    if (full_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_full: fifo_full seen=%b, want 1", full_seen);
    end
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: got %b, want 1", ovf);
    end
    n_checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d writes (idle=%0d), want %0d", obs_q.size(), ok, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL overflow_write%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    debounce_en = 1'b0;
    tick(4);
    for (int j = 0; j < 3; j++) press_fast(8'h61 + 8'(j));
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = E;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midreset_pulse: E never rose within 100 cycles, want 1");
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({E, RS, RW, dout, busy, full, ovf} !== 13'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got E=%b RS=%b RW=%b data=%h busy=%b full=%b ovf=%b, want all 0",
               E, RS, RW, dout, busy, full, ovf);
    end
    tick(2);
    reset = 1'b0;
    obs_q.delete();
    tick(60);
    n_checks++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abandon: got %0d writes busy=%b after reset, want 0 0", obs_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounce();
    test_wrap();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_text_writer.md
LCD_TEXT_WRITER -- requirements
Module: lcd_text_writer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000: button level must be stable this many cycles before it is accepted.
REQ-002 Parameter FIFO_DEPTH, default 16: character FIFO entries, power of two, minimum 2.
REQ-003 Parameter SETUP_CYCLES, default 3: cycles RS/data are stable before E rises.
REQ-004 Parameter E_PULSE_CYCLES, default 12: cycles E is held high.
REQ-005 Parameter EXEC_CYCLES, default 2500: cycles after E falls before the next LCD access.
REQ-006 Parameter COLS, default 16: characters per display line, 1..40.
REQ-007 Parameter ROWS, default 2: display lines, 1 or 2.
REQ-008 clk  in  1  single system clock; all logic on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 data_btn  in  8  ASCII code sampled on each accepted button press.
REQ-011 button  in  1  asynchronous raw push-button, active-high.
REQ-012 debounce_en  in  1  1 = debounce filter active; 0 = synchronized level used directly.
REQ-013 RW_btn_lcd  out  1  LCD R/W; constant 0 (write only).
REQ-014 RS_btn_lcd  out  1  LCD RS; 1 = character data, 0 = command.
REQ-015 E_btn_lcd  out  1  LCD enable strobe.
REQ-016 data_btn_lcd  out  8  LCD data bus.
REQ-017 busy  out  1  high whenever the FSM is not in IDLE.
REQ-018 fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-019 overflow  out  1  sticky; set when a press is dropped, cleared only by reset.

Function
REQ-020 button SHALL pass a 2-flop synchronizer; with debounce_en=1, a counter SHALL update the accepted level only after DEBOUNCE_CYCLES consecutive cycles of the new synchronized level, restarting on any change.
REQ-021 With debounce_en=0, the accepted level SHALL equal the synchronized level; toggling debounce_en SHALL NOT itself generate a press.
REQ-022 An accepted 0->1 transition SHALL push data_btn, sampled in that cycle, into the FIFO one cycle later.
REQ-023 A push while full SHALL be accepted if a pop occurs in the same cycle; otherwise it is dropped and overflow set.
REQ-024 FSM states: IDLE, SETUP, PULSE, WAIT; each state counter SHALL count from 0 to its parameter minus 1.
REQ-025 In IDLE with the FIFO non-empty, the FSM SHALL pop one entry, drive data_btn_lcd=entry and RS=1, and enter SETUP on the next cycle.
REQ-026 SETUP SHALL hold E=0 for SETUP_CYCLES, then PULSE SHALL hold E=1 for E_PULSE_CYCLES, then WAIT SHALL hold E=0 for EXEC_CYCLES; RS/data SHALL be stable from SETUP entry to WAIT exit.
REQ-027 A cursor (col 0..COLS-1, row 0..ROWS-1) SHALL advance col by 1 after each character write completes.
REQ-028 When a character write completes with col=COLS-1, col SHALL reset to 0 and row SHALL advance (row ROWS-1 wraps to 0). The FSM SHALL then go straight to SETUP with RS=0 and data=0x80|base, without popping. base is 0x00 for row 0 and 0x40 for row 1.
REQ-029 After the address command's WAIT, the FSM SHALL return to IDLE; the command does not move the cursor.
REQ-030 Pushes SHALL continue during any FSM state; the FIFO SHALL be popped only in IDLE.
REQ-031 RW_btn_lcd SHALL be 0 at all times.

Reset
REQ-032 Reset SHALL force IDLE, E=0, RS=0, RW=0, data_btn_lcd=0x00, FIFO empty, fifo_full=0, overflow=0, col=0, row=0, and debounce accepted level=0.
REQ-033 Reset asserted mid-transaction SHALL drop E low in the next cycle and abandon the transaction and all FIFO contents.

Verification (bench overrides: DEBOUNCE_CYCLES=4, SETUP_CYCLES=2, E_PULSE_CYCLES=3, EXEC_CYCLES=5, FIFO_DEPTH=4, COLS=4, ROWS=2)
REQ-034 One clean press with data_btn=0x41 and debounce_en=1 -> one transaction: RS=1, data=0x41, E low 2 cycles, then high exactly 3 cycles, then low 5 cycles; busy then returns to 0.
REQ-035 Button bouncing 1-0-1 with 2-cycle pulses, then steady high -> exactly one character written; with debounce_en=0, the same stimulus -> two characters written.
REQ-036 Five presses 0x31..0x35 -> after the 4th character, command RS=0 data=0xC0, then 0x35; after 4 more characters, command 0x80 (wrap).
REQ-037 Six rapid presses while the first write is busy -> FIFO fills, fifo_full=1, overflow=1, written characters are in order with no duplicates, and the excess presses are dropped.
REQ-038 Reset asserted during PULSE -> E=0 on the next cycle, all outputs at reset values, and the queued characters are never written.
